// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the JPEG decoder MCU sequencing slice.
//   slot_t      : encoding of the 8x8 block slot inside an MCU (Y0..Y3, Cb, Cr)
//   COMP_*      : JpegComp values for grayscale and YCbCr streams
//   SUBSAMP_2   : sampling factor value selecting 2x; any other value means 1x
//   next_slot() : slot that follows the current one in a YCbCr MCU
package aq_djpeg_pkg;

    typedef enum logic [2:0] {
        SLOT_Y0 = 3'd0,
        SLOT_Y1 = 3'd1,
        SLOT_Y2 = 3'd2,
        SLOT_Y3 = 3'd3,
        SLOT_CB = 3'd4,
        SLOT_CR = 3'd5
    } slot_t;

    localparam logic [2:0] COMP_GRAY  = 3'd1;
    localparam logic [2:0] COMP_YCBCR = 3'd3;
    localparam logic [1:0] SUBSAMP_2  = 2'd2;

    // Luma slots present: Y0 always, Y1 if 2x wide, Y2 if 2x tall, Y3 if both.
    function automatic slot_t next_slot(input slot_t cur, input logic sw2, input logic sh2);
        slot_t nxt;
        case (cur)
            SLOT_Y0: nxt = sw2 ? SLOT_Y1 : (sh2 ? SLOT_Y2 : SLOT_CB);
            SLOT_Y1: nxt = sh2 ? SLOT_Y2 : SLOT_CB;
            SLOT_Y2: nxt = sw2 ? SLOT_Y3 : SLOT_CB;
            SLOT_Y3: nxt = SLOT_CB;
            SLOT_CB: nxt = SLOT_CR;
            default: nxt = SLOT_Y0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/aq_djpeg_mcu_pos.sv
// MCU coordinate counter for the colour converter side.
//   clk, rst      : clock, asynchronous active-low reset
//   i_clear       : synchronous restart of the counter
//   i_step        : one accepted MCU consumed
//   i_width       : MCUs per row (0 behaves as 1)
//   i_height      : MCU rows (0 behaves as 1)
//   o_mcu_x/y     : coordinate of the MCU currently being converted
//   o_frame_done  : registered one-cycle pulse after the last MCU of a frame
module aq_djpeg_mcu_pos #(
    parameter int BLKW = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_step,
    input  logic [BLKW-1:0] i_width,
    input  logic [BLKW-1:0] i_height,
    output logic [BLKW-1:0] o_mcu_x,
    output logic [BLKW-1:0] o_mcu_y,
    output logic            o_frame_done
);

    logic [BLKW-1:0] r_x;
    logic [BLKW-1:0] r_y;
    logic            r_fd;
    logic [BLKW:0]   w_x_nxt;
    logic [BLKW:0]   w_y_nxt;
    logic            w_last_x;
    logic            w_last_y;

    // One extra bit so x+1 never wraps; ">=" makes a size of 0 act as 1 and
    // keeps a counter that is already past a shrunken size from running away.
    assign w_x_nxt  = {1'b0, r_x} + (BLKW+1)'(1);
    assign w_y_nxt  = {1'b0, r_y} + (BLKW+1)'(1);
    assign w_last_x = (w_x_nxt >= {1'b0, i_width});
    assign w_last_y = (w_y_nxt >= {1'b0, i_height});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x  <= '0;
            r_y  <= '0;
            r_fd <= 1'b0;
        end else if (i_clear) begin
            r_x  <= '0;
            r_y  <= '0;
            r_fd <= 1'b0;
        end else begin
            r_fd <= i_step & w_last_x & w_last_y;
            if (i_step) begin
                if (w_last_x) begin
                    r_x <= '0;
                    if (w_last_y) begin
                        r_y <= '0;
                    end else begin
                        r_y <= w_y_nxt[BLKW-1:0];
                    end
                end else begin
                    r_x <= w_x_nxt[BLKW-1:0];
                end
            end
        end
    end

    assign o_mcu_x      = r_x;
    assign o_mcu_y      = r_y;
    assign o_frame_done = r_fd;

endmodule

// File: rtl/aq_djpeg_mcu_seq.sv
// MCU block sequencer and buffer occupancy tracker between the IDCT writer
// and the colour converter.
//   clk, rst                    : clock, asynchronous active-low reset
//   ProcessInit                 : synchronous restart of all state
//   JpegComp                    : component count (3 = YCbCr, else grayscale)
//   SubSamplingW/H              : luma sampling factors (2 = 2x, else 1x)
//   FrameWidthMcu/HeightMcu     : frame size in MCUs
//   InBlockDone                 : last write of an 8x8 block
//   InColor                     : slot currently being written
//   InMcuDone                   : pulse one cycle after an MCU completes
//   InFull                      : every MCU buffer is occupied
//   ConvMcuDone                 : converter released one MCU
//   ConvValid, Occupancy        : converter has work / buffers in use
//   ConvMcuX/Y, ConvPixelX/Y    : position of the MCU being converted
//   FrameDone                   : pulse after the last MCU of a frame
//   Overflow, Underflow         : sticky protocol error flags
module aq_djpeg_mcu_seq
    import aq_djpeg_pkg::*;
#(
    parameter int BLKW  = 12,
    parameter int DEPTH = 2,
    parameter int PIXW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ProcessInit,
    input  logic [2:0]      JpegComp,
    input  logic [1:0]      SubSamplingW,
    input  logic [1:0]      SubSamplingH,
    input  logic [BLKW-1:0] FrameWidthMcu,
    input  logic [BLKW-1:0] FrameHeightMcu,
    input  logic            InBlockDone,
    output logic [2:0]      InColor,
    output logic            InMcuDone,
    output logic            InFull,
    input  logic            ConvMcuDone,
    output logic            ConvValid,
    output logic [2:0]      Occupancy,
    output logic [BLKW-1:0] ConvMcuX,
    output logic [BLKW-1:0] ConvMcuY,
    output logic [PIXW-1:0] ConvPixelX,
    output logic [PIXW-1:0] ConvPixelY,
    output logic            FrameDone,
    output logic            Overflow,
    output logic            Underflow
);

    slot_t           r_slot;
    logic            r_mcu_done;
    logic [2:0]      r_occ;
    logic            r_ovf;
    logic            r_unf;

    logic            w_sw2;
    logic            w_sh2;
    logic            w_ycc;
    logic            w_full;
    logic            w_valid;
    logic            w_blk_acc;
    logic            w_mcu_last;
    logic            w_conv_acc;
    logic [2:0]      w_shx;
    logic [2:0]      w_shy;
    logic [BLKW+3:0] w_px_full;
    logic [BLKW+3:0] w_py_full;

    assign w_sw2      = (SubSamplingW == SUBSAMP_2);
    assign w_sh2      = (SubSamplingH == SUBSAMP_2);
    assign w_ycc      = (JpegComp == COMP_YCBCR);
    assign w_full     = (r_occ == 3'(DEPTH));
    assign w_valid    = (r_occ != 3'd0);
    assign w_blk_acc  = InBlockDone & ~w_full;
    assign w_mcu_last = ~w_ycc | (r_slot == SLOT_CR);
    assign w_conv_acc = ConvMcuDone & w_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot     <= SLOT_Y0;
            r_mcu_done <= 1'b0;
            r_occ      <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else if (ProcessInit) begin
            r_slot     <= SLOT_Y0;
            r_mcu_done <= 1'b0;
            r_occ      <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_mcu_done <= w_blk_acc & w_mcu_last;
            if (w_blk_acc) begin
                r_slot <= w_ycc ? next_slot(r_slot, w_sw2, w_sh2) : SLOT_Y0;
            end
            if (InBlockDone & w_full) begin
                r_ovf <= 1'b1;
            end
            if (ConvMcuDone & ~w_valid) begin
                r_unf <= 1'b1;
            end
            // InFull lags a completed MCU by two cycles, so back-to-back
            // grayscale blocks can still land while full: saturate and flag.
            case ({r_mcu_done, w_conv_acc})
                2'b10: begin
                    if (w_full) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_occ <= r_occ + 3'd1;
                    end
                end
                2'b01:   r_occ <= r_occ - 3'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    aq_djpeg_mcu_pos #(
        .BLKW (BLKW)
    ) u_pos (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (ProcessInit),
        .i_step       (w_conv_acc & ~ProcessInit),
        .i_width      (FrameWidthMcu),
        .i_height     (FrameHeightMcu),
        .o_mcu_x      (ConvMcuX),
        .o_mcu_y      (ConvMcuY),
        .o_frame_done (FrameDone)
    );

    // An MCU spans 8 pixels per axis, or 16 where that axis is subsampled 2x.
    assign w_shx     = w_sw2 ? 3'd4 : 3'd3;
    assign w_shy     = w_sh2 ? 3'd4 : 3'd3;
    assign w_px_full = (BLKW+4)'(ConvMcuX) << w_shx;
    assign w_py_full = (BLKW+4)'(ConvMcuY) << w_shy;

    assign ConvPixelX = PIXW'(w_px_full);
    assign ConvPixelY = PIXW'(w_py_full);
    assign InColor    = r_slot;
    assign InMcuDone  = r_mcu_done;
    assign InFull     = w_full;
    assign ConvValid  = w_valid;
    assign Occupancy  = r_occ;
    assign Overflow   = r_ovf;
    assign Underflow  = r_unf;

endmodule

// File: tb/tb_aq_djpeg_mcu_seq.sv
// Self-checking bench for aq_djpeg_mcu_seq. Expected InColor values and the
// expected cycles of InMcuDone / FrameDone pulses are queued as stimulus is
// driven and consumed by a negedge monitor when the DUT responds.
module tb_aq_djpeg_mcu_seq;

    localparam int BLKW  = 12;
    localparam int DEPTH = 2;
    localparam int PIXW  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ProcessInit = 1'b0;
    logic [2:0]      JpegComp = 3'd3;
    logic [1:0]      SubSamplingW = 2'd2;
    logic [1:0]      SubSamplingH = 2'd2;
    logic [BLKW-1:0] FrameWidthMcu = 12'd3;
    logic [BLKW-1:0] FrameHeightMcu = 12'd2;
    logic            InBlockDone = 1'b0;
    logic [2:0]      InColor;
    logic            InMcuDone;
    logic            InFull;
    logic            ConvMcuDone = 1'b0;
    logic            ConvValid;
    logic [2:0]      Occupancy;
    logic [BLKW-1:0] ConvMcuX;
    logic [BLKW-1:0] ConvMcuY;
    logic [PIXW-1:0] ConvPixelX;
    logic [PIXW-1:0] ConvPixelY;
    logic            FrameDone;
    logic            Overflow;
    logic            Underflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int color_q[$];
    int mcu_q[$];
    int fd_q[$];

    aq_djpeg_mcu_seq #(
        .BLKW  (BLKW),
        .DEPTH (DEPTH),
        .PIXW  (PIXW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ProcessInit    (ProcessInit),
        .JpegComp       (JpegComp),
        .SubSamplingW   (SubSamplingW),
        .SubSamplingH   (SubSamplingH),
        .FrameWidthMcu  (FrameWidthMcu),
        .FrameHeightMcu (FrameHeightMcu),
        .InBlockDone    (InBlockDone),
        .InColor        (InColor),
        .InMcuDone      (InMcuDone),
        .InFull         (InFull),
        .ConvMcuDone    (ConvMcuDone),
        .ConvValid      (ConvValid),
        .Occupancy      (Occupancy),
        .ConvMcuX       (ConvMcuX),
        .ConvMcuY       (ConvMcuY),
        .ConvPixelX     (ConvPixelX),
        .ConvPixelY     (ConvPixelY),
        .FrameDone      (FrameDone),
        .Overflow       (Overflow),
        .Underflow      (Underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (InBlockDone) begin
            if (color_q.size() == 0) check("color_q_underrun", InBlockDone, 0);
            else check("InColor", InColor, color_q.pop_front());
        end
        if (InMcuDone) begin
            if (mcu_q.size() == 0) check("InMcuDone_spurious", InMcuDone, 0);
            else check("InMcuDone_cycle", cyc, mcu_q.pop_front());
        end
        if (FrameDone) begin
            if (fd_q.size() == 0) check("FrameDone_spurious", FrameDone, 0);
            else check("FrameDone_cycle", cyc, fd_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_fmt(input int comp, input int w, input int h);
        JpegComp     = 3'(comp);
        SubSamplingW = 2'(w);
        SubSamplingH = 2'(h);
    endtask

    task automatic blk(input int slot, input bit completes);
        color_q.push_back(slot);
        if (completes) mcu_q.push_back(cyc + 1);
        InBlockDone = 1'b1;
        @(posedge clk);
        #1;
        InBlockDone = 1'b0;
    endtask

    // mode: 0=444 1=422 2=440 3=420
    task automatic send_mcu(input int mode);
        int s[$];
        case (mode)
            0:       s = '{0, 4, 5};
            1:       s = '{0, 1, 4, 5};
            2:       s = '{0, 2, 4, 5};
            default: s = '{0, 1, 2, 3, 4, 5};
        endcase
        foreach (s[i]) blk(s[i], i == s.size() - 1);
    endtask

    task automatic conv(input int px, input int py, input bit fd);
        check("ConvValid", ConvValid, 1);
        check("ConvPixelX", ConvPixelX, px);
        check("ConvPixelY", ConvPixelY, py);
        if (fd) fd_q.push_back(cyc + 1);
        ConvMcuDone = 1'b1;
        @(posedge clk);
        #1;
        ConvMcuDone = 1'b0;
    endtask

    task automatic check_reset_state(input string t);
        check({t, "_InColor"}, InColor, 0);
        check({t, "_Occupancy"}, Occupancy, 0);
        check({t, "_InFull"}, InFull, 0);
        check({t, "_ConvValid"}, ConvValid, 0);
        check({t, "_ConvMcuX"}, ConvMcuX, 0);
        check({t, "_ConvMcuY"}, ConvMcuY, 0);
        check({t, "_InMcuDone"}, InMcuDone, 0);
        check({t, "_FrameDone"}, FrameDone, 0);
        check({t, "_Overflow"}, Overflow, 0);
        check({t, "_Underflow"}, Underflow, 0);
    endtask

    task automatic do_init();
        check("mcu_pulses_missing", mcu_q.size(), 0);
        check("fd_pulses_missing", fd_q.size(), 0);
        mcu_q.delete();
        fd_q.delete();
        color_q.delete();
        ProcessInit = 1'b1;
        @(posedge clk);
        #1;
        ProcessInit = 1'b0;
        check_reset_state("init");
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst = 1'b1;
        idle(1);

        // 420 sequence, then fill both buffers and overflow on a third MCU
        send_mcu(3);
        send_mcu(3);
        idle(1);
        check("full_occ", Occupancy, 2);
        check("full_InFull", InFull, 1);
        repeat (6) blk(0, 0);
        check("ovf_Overflow", Overflow, 1);
        check("ovf_InColor", InColor, 0);
        check("ovf_occ", Occupancy, 2);
        conv(0, 0, 0);
        check("drain_occ", Occupancy, 1);
        check("drain_InFull", InFull, 0);

        // Simultaneous InMcuDone and ConvMcuDone at occupancy 1
        do_init();
        send_mcu(3);
        idle(1);
        check("sim_pre_occ", Occupancy, 1);
        send_mcu(3);
        conv(0, 0, 0);
        check("sim_occ", Occupancy, 1);
        check("sim_x", ConvMcuX, 1);
        check("sim_unf", Underflow, 0);

        // 422 frame of 3x2 MCUs
        do_init();
        set_fmt(3, 2, 1);
        for (int i = 0; i < 6; i++) begin
            send_mcu(1);
            idle(1);
            conv((i % 3) * 16, (i / 3) * 8, i == 5);
        end
        idle(1);
        check("frm_x", ConvMcuX, 0);
        check("frm_y", ConvMcuY, 0);
        check("frm_occ", Occupancy, 0);
        check("frm_unf", Underflow, 0);

        // Odd sampling values act as 1 (444); width 0 wraps every MCU
        do_init();
        set_fmt(3, 3, 0);
        FrameWidthMcu = '0;
        send_mcu(0);
        send_mcu(0);
        idle(1);
        conv(0, 0, 0);
        check("w0_x", ConvMcuX, 0);
        check("w0_y", ConvMcuY, 1);
        conv(0, 8, 1);
        idle(1);
        check("w0_y_wrap", ConvMcuY, 0);
        FrameWidthMcu = 12'd3;
        set_fmt(3, 1, 2);
        send_mcu(2);
        idle(1);
        check("440_occ", Occupancy, 1);

        // Grayscale: every block is an MCU; underflow when empty
        do_init();
        set_fmt(1, 2, 2);
        blk(0, 1);
        blk(0, 1);
        idle(1);
        check("gray_occ", Occupancy, 2);
        check("gray_color", InColor, 0);
        conv(0, 0, 0);
        conv(16, 0, 0);
        check("gray_empty", Occupancy, 0);
        ConvMcuDone = 1'b1;
        idle(1);
        ConvMcuDone = 1'b0;
        check("unf_flag", Underflow, 1);
        check("unf_occ", Occupancy, 0);
        check("unf_x", ConvMcuX, 2);

        // ProcessInit mid-MCU
        do_init();
        set_fmt(3, 2, 2);
        send_mcu(3);
        idle(1);
        blk(0, 0);
        blk(1, 0);
        blk(2, 0);
        check("mid_color", InColor, 3);
        check("mid_occ", Occupancy, 1);
        do_init();
        send_mcu(3);
        idle(1);
        check("post_init_occ", Occupancy, 1);

        // Asynchronous reset mid-MCU
        blk(0, 0);
        blk(1, 0);
        blk(2, 0);
        check("amid_color", InColor, 3);
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("arst");
        @(posedge clk);
        #1;
        check("arst_hold_InFull", InFull, 0);
        check("arst_hold_ConvValid", ConvValid, 0);
        rst = 1'b1;
        idle(1);
        send_mcu(3);
        idle(1);
        check("post_rst_occ", Occupancy, 1);

        idle(2);
        check("end_mcu_q", mcu_q.size(), 0);
        check("end_fd_q", fd_q.size(), 0);
        check("end_color_q", color_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
